// File: rtl/timer_pkg.sv
// Shared widths, defaults and the binary-to-BCD helper for the round timer.
// Pure definitions: no latency, no flow control.
package timer_pkg;

   localparam int REMAIN_W      = 7;
   localparam int DEFAULT_START = 99;
   localparam int DEFAULT_TICKS = 50_000_000;

   // Tens nibble in [7:4], ones nibble in [3:0]; values above 99 give tens > 9.
   function automatic logic [7:0] to_bcd(input logic [REMAIN_W-1:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v % 7'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICKS_PER_SEC enabled cycles; tick is combinational.
// en low holds the count, so a partial period survives a pause.
module tick_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/round_timer.sv
// Round countdown timer: remain_t drops once per second until it saturates at 0; timeout decodes 0.
// keep freezes the countdown; ROUND_TIMER_BCD_EN adds registered bcd_tens/bcd_ones outputs.
module round_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS,
   parameter int          START_VALUE   = DEFAULT_START
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                keep,
`ifdef ROUND_TIMER_BCD_EN
   output logic [3:0]          bcd_tens,
   output logic [3:0]          bcd_ones,
`endif
   output logic [REMAIN_W-1:0] remain_t,
   output logic                timeout
);

   localparam logic [REMAIN_W-1:0] START = REMAIN_W'(START_VALUE);

   logic run;
   logic tick;

   // At zero the prescaler is disabled, which also parks it at 0 after the final wrap.
   assign run     = !keep && (remain_t != '0);
   assign timeout = (remain_t == '0);

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .reset(reset),
      .en   (run),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remain_t <= START;
      end else if (tick) begin
         remain_t <= remain_t - 7'd1;
      end
   end

`ifdef ROUND_TIMER_BCD_EN
   localparam logic [7:0] START_BCD = to_bcd(START);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_tens <= START_BCD[7:4];
         bcd_ones <= START_BCD[3:0];
      end else if (tick) begin
         if (bcd_ones == 4'd0) begin
            bcd_ones <= 4'd9;
            bcd_tens <= bcd_tens - 4'd1;
         end else begin
            bcd_ones <= bcd_ones - 4'd1;
         end
      end
   end

   bcd_tracks_binary: assert property (@(posedge clk) disable iff (reset)
      {bcd_tens, bcd_ones} == to_bcd(remain_t));
`endif

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: two instances (4 ticks/s from 10, 1 tick/s from 3), plus a BCD instance when enabled.
module tb_round_timer;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1;
   logic       keep_a = 1'b0;
   logic [6:0] remain_a;
   logic       timeout_a;
   logic       rst_b = 1'b1;
   logic       keep_b = 1'b0;
   logic [6:0] remain_b;
   logic       timeout_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   round_timer #(.TICKS_PER_SEC(4), .START_VALUE(10)) u_dut_a (
      .clk     (clk),
      .reset   (rst_a),
      .keep    (keep_a),
`ifdef ROUND_TIMER_BCD_EN
      .bcd_tens(),
      .bcd_ones(),
`endif
      .remain_t(remain_a),
      .timeout (timeout_a)
   );

   round_timer #(.TICKS_PER_SEC(1), .START_VALUE(3)) u_dut_b (
      .clk     (clk),
      .reset   (rst_b),
      .keep    (keep_b),
`ifdef ROUND_TIMER_BCD_EN
      .bcd_tens(),
      .bcd_ones(),
`endif
      .remain_t(remain_b),
      .timeout (timeout_b)
   );

`ifdef ROUND_TIMER_BCD_EN
   logic       rst_c = 1'b1;
   logic       keep_c = 1'b0;
   logic [6:0] remain_c;
   logic       timeout_c;
   logic [3:0] tens_c;
   logic [3:0] ones_c;

   round_timer #(.TICKS_PER_SEC(1), .START_VALUE(99)) u_dut_c (
      .clk     (clk),
      .reset   (rst_c),
      .keep    (keep_c),
      .bcd_tens(tens_c),
      .bcd_ones(ones_c),
      .remain_t(remain_c),
      .timeout (timeout_c)
   );
`endif

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_a_pulse();
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      step(5);
      n_checks++;
      if (remain_a !== 7'd10) begin
         n_errors++;
         $display("FAIL reset_remain: got %0d expected 10", remain_a);
      end
      n_checks++;
      if (timeout_a !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_timeout: got %b expected 0", timeout_a);
      end
      rst_a = 1'b0;
      step(3);
      n_checks++;
      if (remain_a !== 7'd10) begin
         n_errors++;
         $display("FAIL load_3cyc: got %0d expected 10", remain_a);
      end
      step(1);
      n_checks++;
      if (remain_a !== 7'd9) begin
         n_errors++;
         $display("FAIL load_4cyc: got %0d expected 9", remain_a);
      end
      step(8);
      n_checks++;
      if (remain_a !== 7'd7) begin
         n_errors++;
         $display("FAIL load_12cyc: got %0d expected 7", remain_a);
      end
   endtask

   task automatic test_full_countdown();
      int exp_remain;
      reset_a_pulse();
      for (int i = 1; i <= 60; i++) begin
         step(1);
         exp_remain = (i >= 40) ? 0 : 10 - i / 4;
         n_checks++;
         if (remain_a !== 7'(exp_remain) || timeout_a !== (exp_remain == 0)) begin
            n_errors++;
            $display("FAIL countdown cyc %0d: got remain %0d timeout %b expected remain %0d timeout %b",
                     i, remain_a, timeout_a, exp_remain, exp_remain == 0);
         end
      end
      keep_a = 1'b1;
      step(3);
      n_checks++;
      if (remain_a !== 7'd0 || timeout_a !== 1'b1) begin
         n_errors++;
         $display("FAIL keep_at_zero: got remain %0d timeout %b expected 0 1", remain_a, timeout_a);
      end
      keep_a = 1'b0;
   endtask

   task automatic test_pause();
      reset_a_pulse();
      step(6);
      n_checks++;
      if (remain_a !== 7'd9) begin
         n_errors++;
         $display("FAIL pause_pre: got %0d expected 9", remain_a);
      end
      keep_a = 1'b1;
      step(50);
      n_checks++;
      if (remain_a !== 7'd9) begin
         n_errors++;
         $display("FAIL pause_hold: got %0d expected 9", remain_a);
      end
      keep_a = 1'b0;
      step(1);
      n_checks++;
      if (remain_a !== 7'd9) begin
         n_errors++;
         $display("FAIL pause_resume1: got %0d expected 9", remain_a);
      end
      step(1);
      n_checks++;
      if (remain_a !== 7'd8) begin
         n_errors++;
         $display("FAIL pause_resume2: got %0d expected 8", remain_a);
      end
   endtask

   task automatic async_reset_pulse(input string name);
      #2;
      rst_a = 1'b1;
      #1;
      n_checks++;
      if (remain_a !== 7'd10 || timeout_a !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_async: got remain %0d timeout %b expected 10 0", name, remain_a, timeout_a);
      end
      #1;
      rst_a = 1'b0;
      step(3);
      n_checks++;
      if (remain_a !== 7'd10) begin
         n_errors++;
         $display("FAIL %s_3cyc: got %0d expected 10", name, remain_a);
      end
      step(1);
      n_checks++;
      if (remain_a !== 7'd9) begin
         n_errors++;
         $display("FAIL %s_4cyc: got %0d expected 9", name, remain_a);
      end
   endtask

   task automatic test_midrun_reset();
      reset_a_pulse();
      step(20);
      n_checks++;
      if (remain_a !== 7'd5) begin
         n_errors++;
         $display("FAIL midrun_pre: got %0d expected 5", remain_a);
      end
      async_reset_pulse("midrun");
      step(40);
      n_checks++;
      if (timeout_a !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_pre: got %b expected 1", timeout_a);
      end
      async_reset_pulse("after_timeout");
   endtask

   task automatic test_tick_every_cycle();
      n_checks++;
      if (remain_b !== 7'd3 || timeout_b !== 1'b0) begin
         n_errors++;
         $display("FAIL tick1_reset: got remain %0d timeout %b expected 3 0", remain_b, timeout_b);
      end
      rst_b = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         n_checks++;
         if (remain_b !== 7'((i >= 3) ? 0 : 3 - i) || timeout_b !== (i >= 3)) begin
            n_errors++;
            $display("FAIL tick1 edge %0d: got remain %0d timeout %b expected remain %0d timeout %b",
                     i, remain_b, timeout_b, (i >= 3) ? 0 : 3 - i, i >= 3);
         end
      end
   endtask

`ifdef ROUND_TIMER_BCD_EN
   task automatic test_bcd();
      n_checks++;
      if (tens_c !== 4'd9 || ones_c !== 4'd9) begin
         n_errors++;
         $display("FAIL bcd_reset: got %0d%0d expected 99", tens_c, ones_c);
      end
      rst_c = 1'b0;
      step(9);
      n_checks++;
      if (tens_c !== 4'd9 || ones_c !== 4'd0 || remain_c !== 7'd90) begin
         n_errors++;
         $display("FAIL bcd_90: got %0d%0d bin %0d expected 90", tens_c, ones_c, remain_c);
      end
      step(1);
      n_checks++;
      if (tens_c !== 4'd8 || ones_c !== 4'd9 || remain_c !== 7'd89) begin
         n_errors++;
         $display("FAIL bcd_89: got %0d%0d bin %0d expected 89", tens_c, ones_c, remain_c);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_countdown();
      test_pause();
      test_midrun_reset();
      test_tick_every_cycle();
`ifdef ROUND_TIMER_BCD_EN
      test_bcd();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
